// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pipe_ctrl_pkg
// Purpose : Shared encodings for the pipeline controller: per-stage stall
//           codes, the ERET exception code, the zero word and FSM states.
// Revision: 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

  // Single-bit stage hold values
  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // Whole-vector stall patterns (bit0 PC ... bit5 WB)
  localparam logic [5:0] STALL_NONE = {6{NO_STOP}};
  localparam logic [5:0] STALL_ID   = {NO_STOP, NO_STOP, NO_STOP, STOP, STOP, STOP};
  localparam logic [5:0] STALL_EX   = {NO_STOP, NO_STOP, STOP, STOP, STOP, STOP};
  localparam logic [5:0] STALL_MEM  = {NO_STOP, STOP, STOP, STOP, STOP, STOP};

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  localparam logic [31:0] EXC_ERET  = 32'h0000_000e;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_STALL   = 2'd1,
    ST_FLUSHED = 2'd2
  } state_t;

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : pipe_ctrl_if
// Purpose : Bundle of stall/exception requests from the pipeline and the
//           hold/flush/redirect controls plus diagnostics returned to it.
// Revision: 1.0 - initial release
// ============================================================================
interface pipe_ctrl_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic [31:0] mem_excepttype;
  logic [31:0] cp0_epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;
  logic        wdog_trip;

  // Pipeline side: raises requests, consumes controls
  modport master (
    output stallreq_id, stallreq_ex, stallreq_mem, mem_excepttype, cp0_epc,
    input  stall, flush, new_pc, stall_cycles, flush_count, wdog_trip
  );

  // Controller side
  modport slave (
    input  stallreq_id, stallreq_ex, stallreq_mem, mem_excepttype, cp0_epc,
    output stall, flush, new_pc, stall_cycles, flush_count, wdog_trip
  );
endinterface : pipe_ctrl_if
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pipe_ctrl
// Purpose : Pipeline hazard controller. Prioritises exceptions over stall
//           requests, redirects the PC on exceptions, blocks a re-flush for
//           one cycle after each flush, and keeps stall/flush statistics
//           plus a sticky stall watchdog.
// Revision: 1.0 - initial release
// ============================================================================
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
  parameter int unsigned WDOG_LIMIT = 255
) (
  input  wire logic  clk,
  input  wire logic  rst,
  pipe_ctrl_if.slave bus
);

  state_t      state;
  logic [5:0]  stall_sel;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;
  logic [31:0] consec;
  logic [31:0] consec_next;
  logic        wdog_trip;

  // Controls are combinational so pipeline registers act on them at this edge;
  // FLUSHED masks the exception still sitting in MEM for one cycle.
  always_comb begin
    stall_sel = STALL_NONE;
    stall     = STALL_NONE;
    flush     = 1'b0;
    new_pc    = ZERO_WORD;
    if (bus.stallreq_mem)     stall_sel = STALL_MEM;
    else if (bus.stallreq_ex) stall_sel = STALL_EX;
    else if (bus.stallreq_id) stall_sel = STALL_ID;
    if (!rst) begin
      if (state != ST_FLUSHED && bus.mem_excepttype != ZERO_WORD) begin
        flush  = 1'b1;
        new_pc = (bus.mem_excepttype == EXC_ERET) ? bus.cp0_epc : EXC_VECTOR;
      end else begin
        stall = stall_sel;
      end
    end
  end

  // Next value of the consecutive-stall counter (clears on any gap or flush)
  always_comb begin
    consec_next = 32'd0;
    if (!flush && stall != STALL_NONE)
      consec_next = (consec >= WDOG_LIMIT) ? WDOG_LIMIT : consec + 32'd1;
  end

  // Controller state: flush always lands in FLUSHED, otherwise track stalling
  always_ff @(posedge clk) begin
    if (rst)                      state <= ST_RUN;
    else if (flush)               state <= ST_FLUSHED;
    else if (stall != STALL_NONE) state <= ST_STALL;
    else                          state <= ST_RUN;
  end

  // Statistics counters and sticky watchdog; wrap naturally at their widths
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= 32'd0;
      flush_count  <= 16'd0;
      consec       <= 32'd0;
      wdog_trip    <= 1'b0;
    end else begin
      if (stall != STALL_NONE) stall_cycles <= stall_cycles + 32'd1;
      if (flush)               flush_count  <= flush_count + 16'd1;
      consec <= consec_next;
      if (consec_next >= WDOG_LIMIT && consec_next != 32'd0) wdog_trip <= 1'b1;
    end
  end

  assign bus.stall        = stall;
  assign bus.flush        = flush;
  assign bus.new_pc       = new_pc;
  assign bus.stall_cycles = stall_cycles;
  assign bus.flush_count  = flush_count;
  assign bus.wdog_trip    = wdog_trip;

endmodule : pipe_ctrl
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipe_ctrl
// Purpose : Scoreboard bench for pipe_ctrl. Directed steps push expected
//           controls/counters; a negedge monitor pops and compares.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int unsigned LIMIT = 255;

  typedef struct {
    int          tag;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic [31:0] sc;
    logic [15:0] fc;
    logic        wd;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  pipe_ctrl_if bus();

  exp_t q[$];
  int checks   = 0;
  int failures = 0;
  int tag      = 0;

  // Reference state derived from the stimulus
  logic [31:0] m_sc   = 32'd0;
  logic [15:0] m_fc   = 16'd0;
  int          m_cons = 0;
  logic        m_wd   = 1'b0;

  pipe_ctrl #(.EXC_VECTOR(32'h0000_0020), .WDOG_LIMIT(LIMIT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input int t, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%h expected=%h", nm, t, act, exp);
    end
  endtask

  // Monitor: one scoreboard entry per sampled cycle, taken mid-cycle
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      cmp("stall",        e.tag, {26'd0, bus.stall},   {26'd0, e.stall});
      cmp("flush",        e.tag, {31'd0, bus.flush},   {31'd0, e.flush});
      cmp("new_pc",       e.tag, bus.new_pc,           e.pc);
      cmp("stall_cycles", e.tag, bus.stall_cycles,     e.sc);
      cmp("flush_count",  e.tag, {16'd0, bus.flush_count}, {16'd0, e.fc});
      cmp("wdog_trip",    e.tag, {31'd0, bus.wdog_trip}, {31'd0, e.wd});
    end
  end

  // Drive one cycle of inputs, record expectation, advance the reference
  task automatic step(input logic r, input logic id, input logic ex, input logic mem,
                      input logic [31:0] exc, input logic [31:0] epc,
                      input logic [5:0] es, input logic ef, input logic [31:0] epcx);
    exp_t e;
    @(posedge clk);
    #1;
    rst                = r;
    bus.stallreq_id    = id;
    bus.stallreq_ex    = ex;
    bus.stallreq_mem   = mem;
    bus.mem_excepttype = exc;
    bus.cp0_epc        = epc;
    tag++;
    e.tag = tag; e.stall = es; e.flush = ef; e.pc = epcx;
    e.sc = m_sc; e.fc = m_fc; e.wd = m_wd;
    q.push_back(e);
    if (r) begin
      m_sc = 0; m_fc = 0; m_cons = 0; m_wd = 1'b0;
    end else begin
      if (es != 6'd0) m_sc = m_sc + 1;
      if (ef) m_fc = m_fc + 1;
      if (ef || es == 6'd0) m_cons = 0;
      else if (m_cons < int'(LIMIT)) m_cons++;
      if (m_cons == int'(LIMIT)) m_wd = 1'b1;
    end
  endtask

  initial begin
    bus.stallreq_id = 0; bus.stallreq_ex = 0; bus.stallreq_mem = 0;
    bus.mem_excepttype = 0; bus.cp0_epc = 0;

    // Reset dominates pending requests and exceptions
    step(1, 1, 1, 1, 32'h8, 32'h0, 6'b000000, 0, 32'h0);
    step(1, 0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 32'h0);
    step(0, 0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 32'h0);
    // Execute stall for three cycles, then release (counter shows 3)
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 32'h0, 32'h0, 6'b001111, 0, 32'h0);
    step(0, 0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 32'h0);
    // Priority mem > ex > id
    step(0, 1, 1, 1, 32'h0, 32'h0, 6'b011111, 0, 32'h0);
    step(0, 1, 1, 0, 32'h0, 32'h0, 6'b001111, 0, 32'h0);
    step(0, 1, 0, 0, 32'h0, 32'h0, 6'b000111, 0, 32'h0);
    step(0, 0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 32'h0);
    // Exception beats a memory stall; next cycle is masked (FLUSHED)
    step(0, 0, 0, 1, 32'h8, 32'h0, 6'b000000, 1, 32'h20);
    step(0, 0, 0, 1, 32'h8, 32'h0, 6'b011111, 0, 32'h0);
    // ERET from STALL uses EPC; held exception is masked for one cycle only
    step(0, 0, 0, 0, 32'he, 32'h1234, 6'b000000, 1, 32'h1234);
    step(0, 0, 0, 0, 32'he, 32'h1234, 6'b000000, 0, 32'h0);
    step(0, 0, 0, 0, 32'he, 32'h1234, 6'b000000, 1, 32'h1234);
    step(0, 1, 0, 0, 32'h0, 32'h0, 6'b000111, 0, 32'h0);
    // Build stall_cycles to 10 while stalling, then reset mid-stall
    step(0, 0, 1, 0, 32'h0, 32'h0, 6'b001111, 0, 32'h0);
    step(0, 0, 1, 0, 32'h0, 32'h0, 6'b001111, 0, 32'h0);
    step(1, 0, 0, 1, 32'h0, 32'h0, 6'b000000, 0, 32'h0);
    step(0, 0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 32'h0);
    // Reset from FLUSHED with exception pending: RUN afterwards, no flush counted
    step(0, 0, 0, 0, 32'h8, 32'h0, 6'b000000, 1, 32'h20);
    step(1, 0, 0, 0, 32'h8, 32'h0, 6'b000000, 0, 32'h0);
    step(0, 0, 0, 0, 32'h8, 32'h0, 6'b000000, 1, 32'h20);
    step(0, 0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 32'h0);
    // Watchdog: 255 consecutive memory stalls, then sticky until reset
    for (int i = 0; i < int'(LIMIT); i++) step(0, 0, 0, 1, 32'h0, 32'h0, 6'b011111, 0, 32'h0);
    step(0, 0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 32'h0);
    step(0, 0, 0, 1, 32'h0, 32'h0, 6'b011111, 0, 32'h0);
    step(0, 0, 0, 1, 32'h8, 32'h0, 6'b000000, 1, 32'h20);
    step(0, 0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 32'h0);
    step(1, 0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 32'h0);
    step(0, 0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 32'h0);

    // Let the monitor drain, bounded
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_pipe_ctrl
`default_nettype wire

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter EXC_VECTOR, default 32'h0000_0020, meaning the new PC for every non-ERET exception.
REQ-002 SHALL have parameter WDOG_LIMIT, default 255, meaning the number of consecutive stalled cycles that trips the watchdog.
REQ-003 SHALL have port clk, input, 1, system clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port stallreq_id, input, 1, stall request from decode.
REQ-006 SHALL have port stallreq_ex, input, 1, stall request from execute (multi-cycle mul/div).
REQ-007 SHALL have port stallreq_mem, input, 1, stall request from memory access.
REQ-008 SHALL have port mem_excepttype, input, 32, exception code of the instruction in MEM; zero means none, 32'h0000_000e means ERET.
REQ-009 SHALL have port cp0_epc, input, 32, EPC value used as the ERET return target.
REQ-010 SHALL have port stall, output, 6, per-stage hold: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 means stop.
REQ-011 SHALL have port flush, output, 1, clears all pipeline registers at the next edge.
REQ-012 SHALL have port new_pc, output, 32, redirect target, valid while flush=1.
REQ-013 SHALL have port stall_cycles, output, 32, count of cycles with stall!=0.
REQ-014 SHALL have port flush_count, output, 16, count of accepted flushes.
REQ-015 SHALL have port wdog_trip, output, 1, sticky watchdog flag.

Function
REQ-016 SHALL implement an FSM with states RUN, STALL and FLUSHED.
REQ-017 SHALL drive stall, flush and new_pc combinationally from the inputs and current state, so pipeline registers act on them at the same edge.
REQ-018 SHALL, in RUN or STALL with mem_excepttype!=0, drive flush=1 and stall=6'b000000, and then enter FLUSHED.
REQ-019 SHALL drive new_pc=cp0_epc when mem_excepttype==32'h0000_000e, new_pc=EXC_VECTOR for any other nonzero code, and new_pc=0 when flush=0.
REQ-020 SHALL, with no exception, select stall by priority mem > ex > id: stallreq_mem gives 6'b011111, stallreq_ex gives 6'b001111, stallreq_id gives 6'b000111, none gives 6'b000000.
REQ-021 SHALL make exceptions take priority over all stall requests in the same cycle.
REQ-022 SHALL transition RUN to STALL when stall!=0 and no exception; STALL to RUN when the stall requests drop; STALL to STALL while any request holds.
REQ-023 SHALL, in FLUSHED, ignore mem_excepttype (flush=0) for exactly one cycle, evaluate stall requests normally, and then enter STALL or RUN per REQ-022.
REQ-024 SHALL increment stall_cycles by 1, wrapping at 2^32, in each cycle with stall!=0.
REQ-025 SHALL increment flush_count by 1, wrapping at 2^16, in each cycle with flush=1.
REQ-026 SHALL keep an internal consecutive-stall counter that increments while stall!=0, clears whenever stall==0 or flush==1, and saturates at WDOG_LIMIT.
REQ-027 SHALL set wdog_trip when the consecutive-stall counter reaches WDOG_LIMIT, and hold wdog_trip until rst.
REQ-028 SHALL never alter stall or flush because of wdog_trip; it is a diagnostic flag only.

Reset
REQ-029 SHALL, with rst=1 at an edge, set the state to RUN, stall_cycles=0, flush_count=0, wdog_trip=0 and the consecutive-stall counter to 0.
REQ-030 SHALL force stall=0, flush=0 and new_pc=0 combinationally while rst=1, regardless of other inputs.
REQ-031 SHALL let reset override every state, including FLUSHED and a pending exception, with no flush counted.

Structure
REQ-032 SHALL take the stall encodings (stop / no-stop), the ERET code, ZeroWord and the FSM state encodings from the shared defines file.
REQ-033 SHALL contain no sub-module; the counters and FSM are inline.

Verification
REQ-034 SHALL cover: stallreq_ex=1 for 3 cycles -> stall=6'b001111 on each of those cycles, stall_cycles=3, then stall=0.
REQ-035 SHALL cover: stallreq_id=1, stallreq_ex=1 and stallreq_mem=1 together -> stall=6'b011111.
REQ-036 SHALL cover: mem_excepttype=32'h0000_0008 with stallreq_mem=1 -> flush=1, stall=0, new_pc=32'h0000_0020, flush_count=1.
REQ-037 SHALL cover: mem_excepttype=32'h0000_000e and cp0_epc=32'h0000_1234 -> new_pc=32'h0000_1234; an exception held on the next cycle -> flush=0 (FLUSHED).
REQ-038 SHALL cover: stallreq_mem held 255 cycles -> wdog_trip=1 at the 255th, and it stays 1 after the request drops until rst.
REQ-039 SHALL cover: rst=1 asserted during a stall with stall_cycles=10 -> all outputs 0 on the next cycle, state RUN.
